// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, NOP encoding and the fetch queue entry type.
// Imported by the fetch interface, fetch_queue and fetch_unit.
package riscv_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int ILEN       = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ILEN-1:0]       instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: imem, redirect and decode-side bundle of the fetch stage.
// master = fetch_unit side, slave = imem/decode/control side.
interface fetch_unit_if;
  import riscv_pkg::*;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [ILEN-1:0]       imem_data_0;
  logic [ILEN-1:0]       imem_data_1;
  logic                  imem_ready;

  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;

  logic [1:0]            dec_take;
  logic                  dec_valid_0;
  logic                  dec_valid_1;
  logic [ILEN-1:0]       dec_instr_0;
  logic [ILEN-1:0]       dec_instr_1;
  logic [ADDR_WIDTH-1:0] dec_pc_0;
  logic [ADDR_WIDTH-1:0] dec_pc_1;

  modport master (
    output imem_addr,
    input  imem_data_0, imem_data_1, imem_ready,
    input  redirect_valid, redirect_pc,
    input  dec_take,
    output dec_valid_0, dec_valid_1,
    output dec_instr_0, dec_instr_1,
    output dec_pc_0, dec_pc_1
  );

  modport slave (
    input  imem_addr,
    output imem_data_0, imem_data_1, imem_ready,
    output redirect_valid, redirect_pc,
    output dec_take,
    input  dec_valid_0, dec_valid_1,
    input  dec_instr_0, dec_instr_1,
    input  dec_pc_0, dec_pc_1
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: dual-push / dual-pop circular buffer of fetch entries.
// Ports: clk, rst_n (sync, low), flush, push_cnt/push_0/push_1,
// pop_req, count, head_0/head_1 (zero when the slot is empty).
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [1:0]               push_cnt,
  input  fetch_entry_t             push_0,
  input  fetch_entry_t             push_1,
  input  logic [1:0]               pop_req,
  output logic [$clog2(DEPTH):0]   count,
  output fetch_entry_t             head_0,
  output fetch_entry_t             head_1
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   pop_cnt;
  logic [CW-1:0]   req_w;

  // Over-asking decode is clamped to what is actually held.
  assign req_w   = CW'(pop_req);
  assign pop_cnt = (req_w > count) ? count : req_w;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + CW'(push_cnt) - pop_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush) begin
      if (push_cnt != 2'd0)
        mem[tail] <= push_0;
      if (push_cnt == 2'd2)
        mem[tail + PW'(1)] <= push_1;
    end
  end

  assign head_0 = (count >= CW'(1)) ? mem[head] : '0;
  assign head_1 = (count >= CW'(2)) ? mem[head + PW'(1)] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: dual-issue fetch stage; owns fetch_pc and enqueue control.
// Ports: clk, rst_n (sync, low), bus (fetch_unit_if.master),
// perf_fetched, perf_stall (live only with FETCH_PERF_EN, else 0).
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  fetch_unit_if.master      bus,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stall
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [CW-1:0]         q_count;
  logic [CW-1:0]         free;
  logic [1:0]            push_cnt;
  logic                  can_fetch;
  fetch_entry_t          push_0;
  fetch_entry_t          push_1;
  fetch_entry_t          head_0;
  fetch_entry_t          head_1;

  // Free space uses the start-of-cycle count; pops give no credit.
  assign free      = CW'(QUEUE_DEPTH) - q_count;
  assign can_fetch = !bus.redirect_valid && bus.imem_ready;

  always_comb begin
    push_cnt = 2'd0;
    unique case (1'b1)
      !can_fetch:                      push_cnt = 2'd0;
      can_fetch && free >= CW'(2):     push_cnt = 2'd2;
      can_fetch && free == CW'(1):     push_cnt = 2'd1;
      default:                         push_cnt = 2'd0;
    endcase
  end

  always_comb begin
    pc_next = fetch_pc + (ADDR_WIDTH'(push_cnt) << 2);
    if (bus.redirect_valid)
      pc_next = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      fetch_pc <= RESET_PC;
    else
      fetch_pc <= pc_next;
  end

  assign push_0 = '{pc: fetch_pc, instr: bus.imem_data_0};
  assign push_1 = '{pc: fetch_pc + ADDR_WIDTH'(4),
                    instr: bus.imem_data_1};

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.redirect_valid),
    .push_cnt (push_cnt),
    .push_0   (push_0),
    .push_1   (push_1),
    .pop_req  (bus.dec_take),
    .count    (q_count),
    .head_0   (head_0),
    .head_1   (head_1)
  );

  assign bus.imem_addr   = fetch_pc;
  assign bus.dec_valid_0 = (q_count >= CW'(1));
  assign bus.dec_valid_1 = (q_count >= CW'(2));
  assign bus.dec_instr_0 = head_0.instr;
  assign bus.dec_instr_1 = head_1.instr;
  assign bus.dec_pc_0    = head_0.pc;
  assign bus.dec_pc_1    = head_1.pc;

  take_legal: assert property (
    @(posedge clk) disable iff (!rst_n)
    !bus.redirect_valid |-> (CW'(bus.dec_take) <= q_count)
  );

`ifdef FETCH_PERF_EN
  logic [32:0] fetched_sum;

  assign fetched_sum = {1'b0, perf_fetched} + 33'(push_cnt);

  // Counters survive redirects; they saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      if (!bus.redirect_valid && push_cnt == 2'd0 && perf_stall != '1)
        perf_stall <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random + directed stimulus against a queue-based model.
// Model tracks fetch PC and the {pc, instr} list decode should see.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC    (32'h0000_0100),
    .QUEUE_DEPTH (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] q_pc [$];
  logic [31:0] q_in [$];
  logic [31:0] m_pc;
  longint      m_fetched;
  longint      m_stall;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare();
    int n;
    n = q_pc.size();
    check("v0", 64'(bus.dec_valid_0), 64'(n >= 1));
    check("v1", 64'(bus.dec_valid_1), 64'(n >= 2));
    check("pc0", 64'(bus.dec_pc_0), 64'(n >= 1 ? q_pc[0] : 32'h0));
    check("pc1", 64'(bus.dec_pc_1), 64'(n >= 2 ? q_pc[1] : 32'h0));
    check("in0", 64'(bus.dec_instr_0), 64'(n >= 1 ? q_in[0] : 32'h0));
    check("in1", 64'(bus.dec_instr_1), 64'(n >= 2 ? q_in[1] : 32'h0));
    check("addr", 64'(bus.imem_addr), 64'(m_pc));
`ifdef FETCH_PERF_EN
    check("pf", 64'(perf_fetched), 64'(m_fetched));
    check("ps", 64'(perf_stall), 64'(m_stall));
`else
    check("pf", 64'(perf_fetched), 64'h0);
    check("ps", 64'(perf_stall), 64'h0);
`endif
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_in.delete();
    m_pc      = 32'h0000_0100;
    m_fetched = 0;
    m_stall   = 0;
  endtask

  // Called at a negedge; drives one cycle, advances model, checks.
  task automatic step(bit rdy, bit rv, logic [31:0] rpc, int take);
    int free;
    int n;
    bus.imem_ready     = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.dec_take       = 2'(take);
    bus.imem_data_0    = mem_word(m_pc);
    bus.imem_data_1    = mem_word(m_pc + 32'd4);
    if (rv) begin
      q_pc.delete();
      q_in.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      free = 8 - q_pc.size();
      n = rdy ? (free >= 2 ? 2 : free) : 0;
      for (int k = 0; k < take; k++) begin
        void'(q_pc.pop_front());
        void'(q_in.pop_front());
      end
      for (int k = 0; k < n; k++) begin
        q_pc.push_back(m_pc + 32'(4 * k));
        q_in.push_back(mem_word(m_pc + 32'(4 * k)));
      end
      m_pc = m_pc + 32'(4 * n);
      m_fetched = m_fetched + n;
      if (m_fetched > 64'hFFFF_FFFF) m_fetched = 64'hFFFF_FFFF;
      if (n == 0 && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dec_take       = 2'd0;
    bus.redirect_valid = 1'b0;
    bus.imem_ready     = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  function automatic int rand_take();
    int mx;
    mx = q_pc.size() > 2 ? 2 : q_pc.size();
    return int'($urandom_range(0, mx));
  endfunction

  initial begin
    bus.imem_data_0    = '0;
    bus.imem_data_1    = '0;
    bus.imem_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.dec_take       = 2'd0;

    do_reset();
    check("rst_addr", 64'(bus.imem_addr), 64'h100);
    check("rst_v0", 64'(bus.dec_valid_0), 64'h0);

    step(1, 0, 0, 0);
    check("first_pc0", 64'(bus.dec_pc_0), 64'h100);
    check("first_pc1", 64'(bus.dec_pc_1), 64'h104);
    check("first_addr", 64'(bus.imem_addr), 64'h108);

    repeat (4) step(1, 0, 0, 0);
    check("fill_addr", 64'(bus.imem_addr), 64'h120);
    check("fill_v1", 64'(bus.dec_valid_1), 64'h1);
`ifdef FETCH_PERF_EN
    check("fill_stall", 64'(perf_stall), 64'h1);
`endif

    step(0, 0, 0, 1);
    step(1, 0, 0, 0);
    check("single_addr", 64'(bus.imem_addr), 64'h124);

    repeat (30) step(1, 0, 0, 1);

    step(1, 1, 32'h0000_0203, 2);
    check("redir_v0", 64'(bus.dec_valid_0), 64'h0);
    check("redir_addr", 64'(bus.imem_addr), 64'h200);
    step(1, 0, 0, 0);
    check("redir_pc0", 64'(bus.dec_pc_0), 64'h200);

    step(1, 0, 0, 1);
    step(1, 0, 0, 0);
    for (int i = 0; i < 4 && q_pc.size() > 0; i++) begin
      step(0, 0, 0, q_pc.size() > 2 ? 2 : q_pc.size());
      if (q_pc.size() == 1) begin
        check("drain_v1", 64'(bus.dec_valid_1), 64'h0);
        check("drain_v0", 64'(bus.dec_valid_0), 64'h1);
      end
    end

    for (int i = 0; i < 1500; i++) begin
      if (i == 700) begin
        do_reset();
      end else begin
        step(($urandom % 5) != 0,
             ($urandom % 30) == 0,
             $urandom,
             rand_take());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Dual-issue instruction fetch stage; drives instruction_memory's address and consumes its two-word read (instruction at addr and addr+4).
- Holds the fetch PC and a circular fetch queue of {pc, instr} entries; presents up to two in-order instructions per cycle to decode.
- Supports redirects (branch/jump/trap) with a full queue flush.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC after reset.
- QUEUE_DEPTH, 8, fetch-queue entries; one instruction each; power of two, at least 4.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; synchronous, active-low; sampled on rising clk edge
- imem_addr  output  ADDR_WIDTH  byte address to instruction memory; equals fetch_pc
- imem_data_0  input  ILEN  instruction at imem_addr (combinational return)
- imem_data_1  input  ILEN  instruction at imem_addr+4
- imem_ready  input  1  imem data valid this cycle
- redirect_valid  input  1  flush and restart fetch
- redirect_pc  input  ADDR_WIDTH  new fetch address; bits [1:0] ignored (forced 0)
- dec_take  input  2  instructions consumed by decode this cycle (0, 1 or 2)
- dec_valid_0  output  1  queue head valid
- dec_valid_1  output  1  head+1 valid
- dec_instr_0  output  ILEN  head instruction
- dec_instr_1  output  ILEN  head+1 instruction
- dec_pc_0  output  ADDR_WIDTH  head PC
- dec_pc_1  output  ADDR_WIDTH  head+1 PC

Behaviour:
- Reset (rst_n=0 at an edge): fetch_pc=RESET_PC, head=tail=count=0; all dec_valid_* = 0; dec_instr_*/dec_pc_* = 0.
- free = QUEUE_DEPTH - count, using count at the start of the cycle (no same-cycle credit from dequeue).
- Enqueue, when redirect_valid=0 and imem_ready=1:
  - free≥2: push {fetch_pc, imem_data_0} and {fetch_pc+4, imem_data_1}; fetch_pc += 8.
  - free==1: push only {fetch_pc, imem_data_0}; fetch_pc += 4.
  - free==0 or imem_ready=0: no push; fetch_pc holds.
- Dequeue: head += dec_take and count -= dec_take, in the same edge as enqueue. New count = count + pushed - dec_take.
- dec_take > valid entries is illegal. Simulation assertion fires; the RTL clamps the dequeue to the valid count.
- Outputs are combinational from the queue registers: dec_valid_0 = (count≥1), dec_valid_1 = (count≥2). Invalid slots drive 0.
- Latency: a word read from imem in cycle N is visible on dec_* in cycle N+1.
- Redirect (priority over everything): count, head and tail all go to 0; fetch_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00}. No push and no dequeue that cycle. dec_valid_* = 0 next cycle; first new instruction appears 2 cycles after the redirect edge.
- Pointers wrap modulo QUEUE_DEPTH. fetch_pc wraps naturally at 2^ADDR_WIDTH.
- Reset asserted mid-operation discards all queue contents exactly like the reset state; no partial outputs.

Optional Feature:
- Macro FETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32b, count of instructions pushed) and perf_stall (32b, cycles with no push while redirect_valid=0). Both clear on reset, saturate at all-ones, and are not cleared by redirect.
- Undefined: ports are present but tied to 0; no counter registers are synthesised.

Decomposition:
- riscv_pkg: ADDR_WIDTH, ILEN, NOP_INSTR (32'h00000013), typedef fetch_entry_t {logic [ADDR_WIDTH-1:0] pc; logic [ILEN-1:0] instr;}.
- Sub-module fetch_queue: dual-push/dual-pop circular buffer of fetch_entry_t with flush, count, and head/head+1 read ports.
- fetch_unit keeps PC and enqueue control only.

Test Plan:
- Reset with RESET_PC=0x100, dec_take=0 → imem_addr=0x100; next cycle dec_pc_0=0x100, dec_pc_1=0x104, both valid; imem_addr=0x108.
- dec_take=0 held for 5 cycles, DEPTH=8 → queue fills after 4 cycles; imem_addr stops at 0x120; dec_valid_* stay 1; stall counter = 1 (FETCH_PERF_EN).
- Queue at count=7, dec_take=0 → single push of imem_data_0 only; fetch_pc advances by 4; count=8.
- Steady state with dec_take=1 each cycle → in-order PCs 0x100, 0x104, 0x108, … with no gap or duplicate through ≥3 pointer wraps.
- redirect_valid=1 with redirect_pc=0x203 while dec_take=2 → next cycle dec_valid_*=0, imem_addr=0x200; following cycle dec_pc_0=0x200.
- imem_ready=0 for 3 cycles → no push, PC holds; queue drains via dec_take=2; dec_valid_1 drops before dec_valid_0.
